pkt_head_extractor: RTL and testbench

Upstream feeder for `Parser_Top`. It accepts a packet as a stream of 128-bit beats and captures the first HEAD_WIDTH bits into the parser's head vector. It builds the matching metadata vector (packet length, ingress port) and presents both, tagged, as a one-cycle pulse on the parser's `i_head` / `i_meta` inputs after the last beat. Packet payload is not stored or forwarded by this block.

---
 rtl/pkt_head_extractor.sv | 146 ++++++++++++++
 tb/tb_pkt_head_extractor.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_head_extractor.sv
// Captures the first HEAD_WIDTH bits of a beat-streamed packet and emits them,
// with length/port metadata and a sequence tag, as a one-cycle pulse after eop.
module pkt_head_extractor #(
    parameter int unsigned HEAD_WIDTH    = 512,
    parameter int unsigned META_WIDTH    = 256,
    parameter int unsigned TAG_START_BIT = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_valid,
    input  logic                                  i_sop,
    input  logic                                  i_eop,
    input  logic [3:0]                            i_mod,
    input  logic [127:0]                          i_data,
    input  logic [7:0]                            i_port,
    output logic [HEAD_WIDTH+TAG_START_BIT+3:0]   o_head,
    output logic [META_WIDTH+TAG_START_BIT+3:0]   o_meta,
    output logic [15:0]                           o_err_cnt
);

    localparam int unsigned BEAT_W     = 128;
    localparam int unsigned HEAD_BEATS = HEAD_WIDTH / BEAT_W;
    localparam int unsigned HEAD_BYTES = HEAD_WIDTH / 8;
    localparam int unsigned TAG_WIDTH  = TAG_START_BIT + 4;
    localparam int unsigned IDX_W      = $clog2(HEAD_BEATS + 1);
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned PORT_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_BODY = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [HEAD_WIDTH-1:0]      head_q, head_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [PORT_W-1:0]          port_q, port_d;
    logic [TAG_START_BIT-1:0]   seq_q;
    logic                       emit;
    logic                       err_inc;

    logic [4:0]                 beat_bytes;
    logic [BEAT_W-1:0]          beat_masked;
    logic [LEN_W:0]             len_sum;
    logic [LEN_W-1:0]           len_add;
    logic                       short_pkt;
    logic [TAG_WIDTH-1:0]       tag;
    logic [META_WIDTH-1:0]      meta;

    // Beat byte count, tail masking and saturating length accumulation
    always_comb begin
        beat_bytes  = (i_eop && (i_mod != 4'd0)) ? {1'b0, i_mod} : 5'd16;
        beat_masked = '0;
        for (int unsigned b = 0; b < 16; b++) begin
            if (5'(b) < beat_bytes) begin
                beat_masked[BEAT_W-1-8*b -: 8] = i_data[BEAT_W-1-8*b -: 8];
            end
        end
        len_sum = {1'b0, len_q} + (LEN_W+1)'(beat_bytes);
        len_add = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        idx_d   = idx_q;
        len_d   = len_q;
        port_d  = port_q;
        emit    = 1'b0;
        err_inc = 1'b0;

        if (i_valid) begin
            if (i_sop) begin
                // A sop while a packet is open abandons that packet
                err_inc = (state_q != S_IDLE);
                head_d  = '0;
                head_d[HEAD_WIDTH-1 -: BEAT_W] = beat_masked;
                idx_d   = IDX_W'(1);
                len_d   = LEN_W'(beat_bytes);
                port_d  = i_port;
                state_d = (HEAD_BEATS == 1) ? S_BODY : S_HEAD;
            end else if (state_q == S_IDLE) begin
                err_inc = 1'b1;
            end else begin
                if (state_q == S_HEAD) begin
                    for (int unsigned k = 0; k < HEAD_BEATS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            head_d[HEAD_WIDTH-1-BEAT_W*k -: BEAT_W] = beat_masked;
                        end
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_d == IDX_W'(HEAD_BEATS)) begin
                        state_d = S_BODY;
                    end
                end
                len_d = len_add;
            end

            if (i_eop && (i_sop || (state_q != S_IDLE))) begin
                emit    = 1'b1;
                state_d = S_IDLE;
            end
        end
    end

    // Emission payloads, built from the post-beat values
    always_comb begin
        short_pkt = (len_d < LEN_W'(HEAD_BYTES));
        tag       = {1'b1, short_pkt, 2'b01, seq_q};
        meta      = '0;
        meta[META_WIDTH-1 -: LEN_W]        = len_d;
        meta[META_WIDTH-1-LEN_W -: PORT_W] = port_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            head_q    <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            port_q    <= '0;
            seq_q     <= '0;
            o_head    <= '0;
            o_meta    <= '0;
            o_err_cnt <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            port_q  <= port_d;
            o_head  <= emit ? {tag, head_d} : '0;
            o_meta  <= emit ? {tag, meta} : '0;
            if (emit) begin
                seq_q <= seq_q + TAG_START_BIT'(1);
            end
            if (err_inc && (o_err_cnt != 16'hFFFF)) begin
                o_err_cnt <= o_err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_head_extractor.sv
// Randomized bench for pkt_head_extractor: packets are byte queues, expected
// head/meta/tag vectors are computed from the packet bytes.
module tb_pkt_head_extractor;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic          sop;
    logic          eop;
    logic [3:0]    mod;
    logic [127:0]  data;
    logic [7:0]    port;
    logic [523:0]  o_head;
    logic [267:0]  o_meta;
    logic [15:0]   o_err_cnt;

    int            tests = 0;
    int            fails = 0;
    int            early = 0;
    logic [7:0]    exp_seq = 8'd0;
    logic [15:0]   exp_err = 16'd0;
    logic [7:0]    pkt_q[$];

    pkt_head_extractor dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (valid),
        .i_sop     (sop),
        .i_eop     (eop),
        .i_mod     (mod),
        .i_data    (data),
        .i_port    (port),
        .o_head    (o_head),
        .o_meta    (o_meta),
        .o_err_cnt (o_err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [523:0] model_head(input int n, input logic [7:0] seq);
        logic [511:0] h;
        h = '0;
        for (int i = 0; i < n && i < 64; i++) h[511-8*i -: 8] = pkt_q[i];
        return {1'b1, (n < 64), 2'b01, seq, h};
    endfunction

    function automatic logic [267:0] model_meta(input int n, input logic [7:0] p, input logic [7:0] seq);
        logic [15:0] len;
        len = (n > 65535) ? 16'hFFFF : 16'(n);
        return {1'b1, (n < 64), 2'b01, seq, len, p, 232'd0};
    endfunction

    task automatic beat(input logic v, input logic s, input logic e, input logic [3:0] m,
                        input logic [127:0] d, input logic [7:0] p);
        valid = v; sop = s; eop = e; mod = m; data = d; port = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic build_pkt(input int n);
        pkt_q.delete();
        for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom));
    endtask

    // Drives pkt_q as beats (garbage past the last valid byte); returns just after the eop edge.
    task automatic send_pkt(input logic [7:0] p, input int max_beats);
        int n, nb, idx;
        logic [127:0] d;
        n  = pkt_q.size();
        nb = (n + 15) / 16;
        early = 0;
        for (int b = 0; b < nb && b < max_beats; b++) begin
            for (int j = 0; j < 16; j++) begin
                idx = b * 16 + j;
                d[127-8*j -: 8] = (idx < n) ? pkt_q[idx] : 8'($urandom);
            end
            beat(1'b1, b == 0, b == nb - 1, (b == nb - 1) ? 4'(n % 16) : 4'($urandom),
                 d, (b == 0) ? p : 8'($urandom));
            if (b != nb - 1 && o_head !== '0) early++;
        end
        valid = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        tests++;
        if (o_head !== '0 || o_meta !== '0 || o_err_cnt !== 16'd0) begin
            $display("FAIL reset: head_v=%0b meta=%h err=%h required all zero", o_head[523], o_meta, o_err_cnt);
            fails++;
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_fixed_len(input string name, input int n);
        logic [7:0] p;
        logic [523:0] eh;
        logic [267:0] em;
        p = 8'($urandom);
        build_pkt(n);
        eh = model_head(n, exp_seq);
        em = model_meta(n, p, exp_seq);
        send_pkt(p, 1 << 20);
        exp_seq++;
        tests++;
        if (o_head !== eh) begin
            $display("FAIL %s head: got %h required %h", name, o_head, eh);
            fails++;
        end
        tests++;
        if (o_meta !== em) begin
            $display("FAIL %s meta: got %h required %h", name, o_meta, em);
            fails++;
        end
        tests++;
        if (early != 0) begin
            $display("FAIL %s early pulse: got %0d required 0", name, early);
            fails++;
        end
        idle(1);
        tests++;
        if (o_head !== '0 || o_meta !== '0) begin
            $display("FAIL %s pulse width: head_v=%0b required 0", name, o_head[523]);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] p;
        logic [523:0] eh;
        logic [267:0] em;
        for (int i = 0; i < 24; i++) begin
            n = (i == 0) ? 1500 : int'($urandom_range(1, 100));
            p = 8'($urandom);
            build_pkt(n);
            eh = model_head(n, exp_seq);
            em = model_meta(n, p, exp_seq);
            send_pkt(p, 1 << 20);
            exp_seq++;
            tests++;
            if (o_head !== eh || o_meta !== em || early != 0) begin
                $display("FAIL b2b pkt%0d len%0d: head %h meta %h early %0d required head %h meta %h",
                         i, n, o_head, o_meta, early, eh, em);
                fails++;
            end
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);
    endtask

    task automatic test_errors();
        logic [7:0] p;
        logic [523:0] eh;
        logic [267:0] em;
        beat(1'b1, 1'b0, 1'b0, 4'd0, 128'($urandom), 8'd3);
        exp_err++;
        tests++;
        if (o_err_cnt !== exp_err || o_head !== '0) begin
            $display("FAIL orphan: err %0d head_v %0b required err %0d head_v 0", o_err_cnt, o_head[523], exp_err);
            fails++;
        end
        // first packet abandoned after two beats, second restarts on its sop
        build_pkt(80);
        send_pkt(8'hAA, 2);
        p = 8'($urandom);
        build_pkt(int'($urandom_range(20, 90)));
        eh = model_head(pkt_q.size(), exp_seq);
        em = model_meta(pkt_q.size(), p, exp_seq);
        send_pkt(p, 1 << 20);
        exp_err++;
        exp_seq++;
        tests++;
        if (o_err_cnt !== exp_err) begin
            $display("FAIL midsop err: got %0d required %0d", o_err_cnt, exp_err);
            fails++;
        end
        tests++;
        if (o_head !== eh || o_meta !== em || early != 0) begin
            $display("FAIL midsop emit: head %h meta %h early %0d required head %h meta %h",
                     o_head, o_meta, early, eh, em);
            fails++;
        end
        valid = 1'b1; sop = 1'b0; eop = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        exp_err = 16'hFFFF;
        tests++;
        if (o_err_cnt !== exp_err) begin
            $display("FAIL err saturate: got %h required %h", o_err_cnt, exp_err);
            fails++;
        end
        idle(1);
    endtask

    task automatic test_reset_mid_and_wrap();
        int bad;
        logic [7:0] p;
        logic [523:0] eh;
        logic [267:0] em;
        build_pkt(64);
        send_pkt(8'h11, 2);
        rst_n = 1'b0;
        beat(1'b1, 1'b0, 1'b0, 4'd0, 128'($urandom), 8'h11);
        rst_n = 1'b1;
        exp_seq = 8'd0;
        exp_err = 16'd0;
        bad = 0;
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (o_head !== '0 || o_meta !== '0) bad++;
            idle(1);
        end
        tests++;
        if (bad != 0 || o_err_cnt !== exp_err) begin
            $display("FAIL reset mid: nonzero cycles %0d err %0d required 0 and %0d", bad, o_err_cnt, exp_err);
            fails++;
        end
        bad = 0;
        for (int i = 0; i < 257; i++) begin
            p = 8'($urandom);
            build_pkt(int'($urandom_range(1, 40)));
            eh = model_head(pkt_q.size(), exp_seq);
            em = model_meta(pkt_q.size(), p, exp_seq);
            send_pkt(p, 1 << 20);
            if (o_head !== eh || o_meta !== em) begin
                if (bad == 0)
                    $display("FAIL wrap pkt%0d: seq got %0d required %0d", i, o_head[519:512], exp_seq);
                bad++;
            end
            exp_seq++;
        end
        tests++;
        if (bad != 0) begin
            $display("FAIL wrap total: %0d bad emissions required 0", bad);
            fails++;
        end
        tests++;
        if (exp_seq != 8'd1 || o_head[519:512] !== 8'd0) begin
            $display("FAIL wrap last seq: got %0d required 0", o_head[519:512]);
            fails++;
        end
        idle(1);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; sop = 1'b0; eop = 1'b0;
        mod = 4'd0; data = '0; port = '0;
        test_reset();
        test_fixed_len("arp64", 64);
        test_fixed_len("tcp60", 60);
        test_fixed_len("single14", 14);
        test_fixed_len("long1500", 1500);
        test_back_to_back();
        test_errors();
        test_reset_mid_and_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
